// File: rtl/key_step_pkg.sv
// Shared types for the step-key conditioner: FSM state encoding and default counter width.
package key_step_pkg;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_PRESS_DEB   = 3'd1,
    S_HELD        = 3'd2,
    S_REPEAT      = 3'd3,
    S_RELEASE_DEB = 3'd4
  } state_t;

  localparam int KS_CNT_W = 25;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for an asynchronous level input, with a configurable reset value.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_meta <= RST_VAL;
      o_q    <= RST_VAL;
    end else begin
      r_meta <= i_d;
      o_q    <= r_meta;
    end
  end

endmodule

// File: rtl/key_step_conditioner.sv
// Turns a bouncing active-low step key plus a direction switch into a clean one-cycle
// step pulse (with optional hold-to-repeat) and a direction level that only moves on a step.
module key_step_conditioner
  import key_step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int CNT_W           = KS_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  input  logic sw_dir,
  output logic step,
  output logic dir,
  output logic pressed
);

  localparam logic [CNT_W-1:0] DEB_C = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] DLY_C = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_C = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  logic             w_key_s;
  logic             w_dir_s;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_step;
  logic             r_dir;
  logic             r_pressed;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + ONE_C;
  endfunction

  sync2 #(.RST_VAL(1'b1)) u_sync_key (
    .i_clk     (clk),
    .i_reset_n (reset),
    .i_d       (key_n),
    .o_q       (w_key_s)
  );

  sync2 #(.RST_VAL(1'b1)) u_sync_dir (
    .i_clk     (clk),
    .i_reset_n (reset),
    .i_d       (sw_dir),
    .o_q       (w_dir_s)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_step    <= 1'b0;
      r_dir     <= 1'b0;
      r_pressed <= 1'b0;
    end else begin
      r_step <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_pressed <= 1'b0;
          if (!w_key_s) begin
            r_state <= S_PRESS_DEB;
            r_cnt   <= ONE_C;
          end else begin
            r_cnt <= '0;
          end
        end
        S_PRESS_DEB: begin
          if (w_key_s) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == DEB_C) begin
            r_state   <= S_HELD;
            r_cnt     <= '0;
            r_step    <= 1'b1;
            r_dir     <= w_dir_s;
            r_pressed <= 1'b1;
          end else begin
            r_cnt <= sat_inc(r_cnt);
          end
        end
        S_HELD: begin
          if (w_key_s) begin
            r_state <= S_RELEASE_DEB;
            r_cnt   <= ONE_C;
          end else if ((REPEAT_EN != 0) && (r_cnt == DLY_C)) begin
            r_state <= S_REPEAT;
            r_cnt   <= '0;
            r_step  <= 1'b1;
            r_dir   <= w_dir_s;
          end else begin
            r_cnt <= sat_inc(r_cnt);
          end
        end
        S_REPEAT: begin
          if (w_key_s) begin
            r_state <= S_RELEASE_DEB;
            r_cnt   <= ONE_C;
          end else if (r_cnt == PER_C) begin
            r_cnt  <= '0;
            r_step <= 1'b1;
            r_dir  <= w_dir_s;
          end else begin
            r_cnt <= sat_inc(r_cnt);
          end
        end
        S_RELEASE_DEB: begin
          // A re-press while releasing returns to HELD, so the repeat delay starts over.
          if (!w_key_s) begin
            r_state <= S_HELD;
            r_cnt   <= '0;
          end else if (r_cnt == DEB_C) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_pressed <= 1'b0;
          end else begin
            r_cnt <= sat_inc(r_cnt);
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_cnt     <= '0;
          r_pressed <= 1'b0;
        end
      endcase
    end
  end

  assign step    = r_step;
  assign dir     = r_dir;
  assign pressed = r_pressed;

endmodule

// File: tb/tb_key_step_conditioner.sv
// Scoreboard bench: a behavioural model predicts step events and levels; a monitor checks the DUT.
module tb_key_step_conditioner;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic key_n = 1'b1;
  logic sw_dir = 1'b0;
  logic step, dir, pressed;

  always #5 clk = ~clk;

  key_step_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_EN       (1),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP),
    .CNT_W           (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .key_n   (key_n),
    .sw_dir  (sw_dir),
    .step    (step),
    .dir     (dir),
    .pressed (pressed)
  );

  typedef struct {
    int   c;
    logic d;
  } ev_t;

  ev_t q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;

  // Reference model: inputs reach the decision logic two edges late; a press or
  // release is accepted after D+1 consecutive edges at the new level.
  logic kh1 = 1'b1, kh2 = 1'b1, dh1 = 1'b1, dh2 = 1'b1;
  logic m_pressed = 1'b0, m_dir = 1'b0;
  int   run_lo = 0, run_hi = 0, since = 0;
  bit   rep = 1'b0;

  always @(posedge clk) begin
    logic ks, ds;
    ev_t  e;
    cyc++;
    ks = kh2;
    ds = dh2;
    if (!reset) begin
      kh1 = 1'b1; kh2 = 1'b1; dh1 = 1'b1; dh2 = 1'b1;
      m_pressed = 1'b0; m_dir = 1'b0;
      run_lo = 0; run_hi = 0; since = 0; rep = 1'b0;
    end else begin
      kh2 = kh1; kh1 = key_n;
      dh2 = dh1; dh1 = sw_dir;
      if (!m_pressed) begin
        run_lo = (ks == 1'b0) ? run_lo + 1 : 0;
        if (run_lo == D + 1) begin
          m_pressed = 1'b1; m_dir = ds;
          run_lo = 0; since = 0; rep = 1'b0;
          e.c = cyc; e.d = ds; q.push_back(e);
        end
      end else if (ks == 1'b1) begin
        run_hi++;
        if (run_hi == D + 1) begin
          m_pressed = 1'b0;
          run_hi = 0;
        end
      end else if (run_hi > 0) begin
        run_hi = 0; since = 0; rep = 1'b0;
      end else begin
        since++;
        if (since == (rep ? RP : RD)) begin
          m_dir = ds; since = 0; rep = 1'b1;
          e.c = cyc; e.d = ds; q.push_back(e);
        end
      end
    end
  end

  always @(negedge clk) begin
    ev_t e;
    if (cyc > 0) begin
      if (q.size() > 0 && q[0].c < cyc) begin
        checks++; errors++;
        $display("FAIL missed_step: expected at cycle %0d, still absent at cycle %0d", q[0].c, cyc);
        void'(q.pop_front());
      end
      if (step === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL spurious_step: step=1 at cycle %0d, none expected", cyc);
        end else begin
          e = q.pop_front();
          if (e.c != cyc || e.d !== dir) begin
            errors++;
            $display("FAIL step_event: got cycle %0d dir %b, expected cycle %0d dir %b", cyc, dir, e.c, e.d);
          end
        end
      end else if (step !== 1'b0) begin
        checks++; errors++;
        $display("FAIL step_level: step=%b at cycle %0d, expected 0/1", step, cyc);
      end
      checks++;
      if (pressed !== m_pressed) begin
        errors++;
        $display("FAIL pressed: got %b expected %b at cycle %0d", pressed, m_pressed, cyc);
      end
      checks++;
      if (dir !== m_dir) begin
        errors++;
        $display("FAIL dir: got %b expected %b at cycle %0d", dir, m_dir, cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset held with key pressed, then release with key still held.
    reset = 1'b0; key_n = 1'b0; sw_dir = 1'b1;
    tick(3);
    reset = 1'b1;
    tick(12);
    // Keep holding into auto-repeat.
    tick(25);
    // Short release bounce during REPEAT, then hold again.
    key_n = 1'b1; tick(2);
    key_n = 1'b0; tick(14);
    // Toggle direction between repeat steps.
    for (int i = 0; i < 4; i++) begin
      sw_dir = ~sw_dir; tick(2);
    end
    tick(10);
    // Reset mid-REPEAT, key held through release.
    reset = 1'b0; tick(1);
    reset = 1'b1; tick(15);
    key_n = 1'b1; tick(12);
    // Press bounce then a clean hold.
    key_n = 1'b0; tick(2);
    key_n = 1'b1; tick(1);
    key_n = 1'b0; tick(10);
    key_n = 1'b1; tick(10);
    // Randomised bouncing, switching and occasional resets.
    for (int s = 0; s < 250; s++) begin
      key_n = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) sw_dir = ~sw_dir;
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b0; tick($urandom_range(1, 2));
        reset = 1'b1;
      end
      tick($urandom_range(1, 24));
    end
    key_n = 1'b1;
    tick(D + 4);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL leftover_steps: %0d expected steps never observed, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
